// File: rtl/store_drain_sched.sv
// Store buffer and dcache port scheduler. Committed stores wait in a circular FIFO
// and share one dcache request port with loads. Loads are delayed when they overlap a buffered store.
package store_drain_sched_pkg;
    localparam int SD_ADDR_WIDTH = 32;
    localparam int SD_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       valid;
        logic [SD_DATA_WIDTH/8-1:0] wstrb;
        logic [SD_ADDR_WIDTH-1:0]   waddr;
        logic [SD_DATA_WIDTH-1:0]   wdata;
    } store_req_t;
endpackage

module store_drain_sched
    import store_drain_sched_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_WIDTH   = SD_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SD_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  store_req_t              store_i,
    output logic                    store_ready_o,
    input  logic                    load_valid_i,
    input  logic [ADDR_WIDTH-1:0]   load_addr_i,
    output logic                    load_grant_o,
    output logic                    load_conflict_o,
    input  logic                    drain_i,
    output logic                    dc_valid_o,
    output logic                    dc_we_o,
    output logic [ADDR_WIDTH-1:0]   dc_addr_o,
    output logic [DATA_WIDTH/8-1:0] dc_wstrb_o,
    output logic [DATA_WIDTH-1:0]   dc_wdata_o,
    input  logic                    dc_ready_i,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int STRB_W   = DATA_WIDTH / 8;

    localparam logic [PTR_W:0]      FULL_CNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]      CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD_REQ, STORE_REQ} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  dc_valid_q, dc_valid_d;
    logic                  dc_we_q, dc_we_d;
    logic [ADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;
    logic [STRB_W-1:0]     dc_wstrb_q, dc_wstrb_d;
    logic [DATA_WIDTH-1:0] dc_wdata_q, dc_wdata_d;
    logic                  load_grant_q, load_grant_d;

    logic [ADDR_WIDTH-1:0] waddr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];
    logic [STRB_W-1:0]     wstrb_mem [DEPTH];

    logic             enq;
    logic             deq;
    logic             load_ok;
    logic             store_win;
    logic [DEPTH-1:0] entry_match;

    // Slot gi is live when its distance from the head is below the occupancy.
    // The in-flight head stays live until its handshake, so it is always checked.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [PTR_W-1:0] offset;
        assign offset = PTR_W'(gi) - rptr_q;
        assign entry_match[gi] = ({1'b0, offset} < count_q) &&
            (waddr_mem[gi][ADDR_WIDTH-1:2] == load_addr_i[ADDR_WIDTH-1:2]);
    end

    assign load_conflict_o = load_valid_i && (|entry_match);

    always_comb begin
        enq       = store_i.valid && (count_q < FULL_CNT);
        deq       = (state_q == STORE_REQ) && dc_ready_i;
        load_ok   = load_valid_i && !load_conflict_o;
        store_win = (count_q != '0) &&
                    (drain_i || (count_q == FULL_CNT) || (starve_q == STARVE_MAX) || !load_ok);

        state_d      = state_q;
        rptr_d       = rptr_q;
        starve_d     = starve_q;
        dc_valid_d   = dc_valid_q;
        dc_we_d      = dc_we_q;
        dc_addr_d    = dc_addr_q;
        dc_wstrb_d   = dc_wstrb_q;
        dc_wdata_d   = dc_wdata_q;
        load_grant_d = 1'b0;
        wptr_d       = enq ? wptr_q + PTR_ONE : wptr_q;

        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (store_win) begin
                    state_d    = STORE_REQ;
                    dc_valid_d = 1'b1;
                    dc_we_d    = 1'b1;
                    dc_addr_d  = waddr_mem[rptr_q];
                    dc_wstrb_d = wstrb_mem[rptr_q];
                    dc_wdata_d = wdata_mem[rptr_q];
                    starve_d   = '0;
                end else if (load_ok) begin
                    state_d      = LOAD_REQ;
                    dc_valid_d   = 1'b1;
                    dc_we_d      = 1'b0;
                    dc_addr_d    = load_addr_i;
                    dc_wstrb_d   = '0;
                    dc_wdata_d   = '0;
                    load_grant_d = 1'b1;
                    if (count_q == '0)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + STARVE_ONE;
                end
            end
            LOAD_REQ: begin
                if (dc_ready_i) begin
                    state_d    = IDLE;
                    dc_valid_d = 1'b0;
                end
            end
            STORE_REQ: begin
                if (dc_ready_i) begin
                    state_d    = IDLE;
                    dc_valid_d = 1'b0;
                    rptr_d     = rptr_q + PTR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            dc_valid_q   <= 1'b0;
            dc_we_q      <= 1'b0;
            dc_addr_q    <= '0;
            dc_wstrb_q   <= '0;
            dc_wdata_q   <= '0;
            load_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            dc_valid_q   <= dc_valid_d;
            dc_we_q      <= dc_we_d;
            dc_addr_q    <= dc_addr_d;
            dc_wstrb_q   <= dc_wstrb_d;
            dc_wdata_q   <= dc_wdata_d;
            load_grant_q <= load_grant_d;
        end
    end

    // Payload only; occupancy and pointers decide which slots mean anything.
    always_ff @(posedge clk) begin
        if (enq) begin
            waddr_mem[wptr_q] <= ADDR_WIDTH'(store_i.waddr);
            wdata_mem[wptr_q] <= DATA_WIDTH'(store_i.wdata);
            wstrb_mem[wptr_q] <= STRB_W'(store_i.wstrb);
        end
    end

    assign store_ready_o = (count_q < FULL_CNT);
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign load_grant_o  = load_grant_q;
    assign dc_valid_o    = dc_valid_q;
    assign dc_we_o       = dc_we_q;
    assign dc_addr_o     = dc_addr_q;
    assign dc_wstrb_o    = dc_wstrb_q;
    assign dc_wdata_o    = dc_wdata_q;
endmodule

// File: tb/tb_store_drain_sched.sv
// Directed bench for store_drain_sched: hand-computed expectations per scenario,
// plus an in-order scoreboard of the stores expected on the dcache port.
module tb_store_drain_sched;
    import store_drain_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    store_req_t  store_i;
    logic        store_ready_o;
    logic        load_valid_i;
    logic [31:0] load_addr_i;
    logic        load_grant_o;
    logic        load_conflict_o;
    logic        drain_i;
    logic        dc_valid_o;
    logic        dc_we_o;
    logic [31:0] dc_addr_o;
    logic [3:0]  dc_wstrb_o;
    logic [31:0] dc_wdata_o;
    logic        dc_ready_i;
    logic        empty_o;
    logic [2:0]  count_o;

    int n_cmp = 0;
    int n_bad = 0;
    store_req_t sb_q[$];
    store_req_t sb_exp;

    store_drain_sched #(
        .DEPTH(4), .STARVE_LIMIT(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .store_i(store_i), .store_ready_o(store_ready_o),
        .load_valid_i(load_valid_i), .load_addr_i(load_addr_i),
        .load_grant_o(load_grant_o), .load_conflict_o(load_conflict_o),
        .drain_i(drain_i), .dc_valid_o(dc_valid_o), .dc_we_o(dc_we_o),
        .dc_addr_o(dc_addr_o), .dc_wstrb_o(dc_wstrb_o), .dc_wdata_o(dc_wdata_o),
        .dc_ready_i(dc_ready_i), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit expect_accept);
        store_i = '{valid: 1'b1, wstrb: s, waddr: a, wdata: d};
        if (expect_accept) sb_q.push_back(store_i);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while ((!empty_o || dc_valid_o) && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_empty"}, empty_o, 1);
        check({tag, "_sb_left"}, sb_q.size(), 0);
    endtask

    // A store handshake completes on the next rising edge; compare it against the oldest expected store.
    always @(negedge clk) begin
        if (!rst && dc_valid_o && dc_we_o && dc_ready_i) begin
            check("st_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check("st_addr", dc_addr_o, sb_exp.waddr);
                check("st_data", dc_wdata_o, sb_exp.wdata);
                check("st_strb", dc_wstrb_o, sb_exp.wstrb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        bit seen;
        rst = 1'b1;
        store_i = '0;
        load_valid_i = 1'b0;
        load_addr_i = '0;
        drain_i = 1'b0;
        dc_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dc_valid", dc_valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_store_ready", store_ready_o, 1);
        check("rst_grant", load_grant_o, 0);
        check("rst_dc_addr", dc_addr_o, 0);
        rst = 1'b0;

        // Single store: request two edges after it is offered, gone after the handshake
        dc_ready_i = 1'b1;
        put_store(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1);
        tick();
        store_i = '0;
        check("t1_count", count_o, 1);
        check("t1_not_yet", dc_valid_o, 0);
        tick();
        check("t1_valid", dc_valid_o, 1);
        check("t1_we", dc_we_o, 1);
        tick();
        check("t1_empty", empty_o, 1);
        check("t1_idle", dc_valid_o, 0);

        // Fill to DEPTH with the port stalled; the fifth store must be refused
        dc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put_store(32'h1000 + 32'(i) * 32'h10, 32'hA000_0000 + 32'(i), 4'(i + 3), (i < 4));
            tick();
            check("t2_count", count_o, (i < 4) ? i + 1 : 4);
            if (i == 3) check("t2_full_ready", store_ready_o, 0);
        end
        check("t2_still_full", store_ready_o, 0);
        dc_ready_i = 1'b1;
        tick();
        check("t2_deq_at_full", count_o, 3);
        store_i = '0;
        wait_empty("t2");

        // Enqueue and dequeue on the same edge
        dc_ready_i = 1'b0;
        put_store(32'h2000, 32'hB000_0000, 4'hF, 1'b1);
        tick();
        put_store(32'h2010, 32'hB000_0001, 4'h1, 1'b1);
        tick();
        check("t3_inflight", dc_valid_o, 1);
        put_store(32'h2020, 32'hB000_0002, 4'hC, 1'b1);
        dc_ready_i = 1'b1;
        tick();
        check("t3_count_same", count_o, 2);
        store_i = '0;
        wait_empty("t3");

        // Load overlapping a buffered store waits for that store
        dc_ready_i = 1'b0;
        put_store(32'h200, 32'hC0DE_0200, 4'hF, 1'b1);
        tick();
        store_i = '0;
        load_valid_i = 1'b1;
        load_addr_i = 32'h204;
        #1;
        check("t4_other_word", load_conflict_o, 0);
        load_addr_i = 32'h202;
        #1;
        check("t4_conflict", load_conflict_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_grant", load_grant_o, 0);
            check("t4_conf_held", load_conflict_o, 1);
        end
        dc_ready_i = 1'b1;
        tick();
        check("t4_conf_clear", load_conflict_o, 0);
        tick();
        check("t4_grant", load_grant_o, 1);
        check("t4_valid", dc_valid_o, 1);
        check("t4_addr", dc_addr_o, 32'h202);
        check("t4_we", dc_we_o, 0);
        check("t4_strb", dc_wstrb_o, 0);
        load_valid_i = 1'b0;
        tick();
        check("t4_grant_pulse", load_grant_o, 0);
        check("t4_idle", dc_valid_o, 0);

        // Starvation: the store is buffered while a load is stalled, then loads stream
        dc_ready_i = 1'b0;
        load_valid_i = 1'b1;
        load_addr_i = 32'h400;
        tick();
        check("t5_first_grant", load_grant_o, 1);
        put_store(32'h300, 32'h5555_0300, 4'h6, 1'b1);
        tick();
        store_i = '0;
        check("t5_count", count_o, 1);
        dc_ready_i = 1'b1;
        grants = 0;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            if (load_grant_o) grants++;
            if (dc_valid_o && dc_we_o) seen = 1'b1;
        end
        check("t5_store_issued", seen, 1);
        check("t5_grants", grants, 8);
        check("t5_starve_clr", dut.starve_q, 0);
        load_valid_i = 1'b0;
        wait_empty("t5");

        // Drain with a stalled first store and a pending non-conflicting load
        dc_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_store(32'h500 + 32'(i) * 32'h8, 32'hD000_0000 + 32'(i), 4'hF, 1'b1);
            tick();
        end
        store_i = '0;
        drain_i = 1'b1;
        load_valid_i = 1'b1;
        load_addr_i = 32'h900;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold_valid", dc_valid_o, 1);
            check("t6_hold_addr", dc_addr_o, 32'h500);
            check("t6_hold_data", dc_wdata_o, 32'hD000_0000);
            check("t6_no_grant", load_grant_o, 0);
        end
        dc_ready_i = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            tick();
            if (load_grant_o) seen = 1'b1;
        end
        check("t6_load_granted", seen, 1);
        check("t6_stores_first", sb_q.size(), 0);
        check("t6_empty", empty_o, 1);
        check("t6_load_addr", dc_addr_o, 32'h900);
        drain_i = 1'b0;
        load_valid_i = 1'b0;
        tick();

        // Reset while a store request is outstanding with two entries buffered
        dc_ready_i = 1'b0;
        put_store(32'h600, 32'hE000_0000, 4'hF, 1'b1);
        tick();
        put_store(32'h610, 32'hE000_0001, 4'hF, 1'b1);
        tick();
        store_i = '0;
        check("t7_inflight", dc_valid_o, 1);
        check("t7_count", count_o, 2);
        rst = 1'b1;
        #1;
        check("t7_valid", dc_valid_o, 0);
        check("t7_count_rst", count_o, 0);
        check("t7_empty", empty_o, 1);
        check("t7_ready", store_ready_o, 1);
        check("t7_we", dc_we_o, 0);
        check("t7_addr", dc_addr_o, 0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("t7_after_valid", dc_valid_o, 0);
        check("t7_after_count", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/store_drain_sched.md
STORE_DRAIN_SCHED -- requirements
Module: store_drain_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4: store buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive load grants allowed while stores pend.
REQ-003 SHALL have parameters ADDR_WIDTH=32 and DATA_WIDTH=32, with wstrb width DATA_WIDTH/8.
REQ-004 clk  in  1  core clock; one clock domain, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 store_i  in  store_req_t  committed store {valid, wstrb, waddr, wdata}.
REQ-007 store_ready_o  out  1  buffer accepts store_i this cycle.
REQ-008 load_valid_i  in  1  load requests the dcache port.
REQ-009 load_addr_i  in  ADDR_WIDTH  load address.
REQ-010 load_grant_o  out  1  load captured into the dcache request register this cycle.
REQ-011 load_conflict_o  out  1  load overlaps a buffered store; load is not granted.
REQ-012 drain_i  in  1  barrier/cacop: stores get priority until empty.
REQ-013 dc_valid_o / dc_we_o / dc_addr_o / dc_wstrb_o / dc_wdata_o  out  1/1/ADDR_WIDTH/4/DATA_WIDTH  dcache request.
REQ-014 dc_ready_i  in  1  dcache accepts the request.
REQ-015 empty_o  out  1  no buffered stores; count_o  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-016 Buffer SHALL be a circular FIFO (wptr, rptr, count); stores drain in commit order.
REQ-017 store_ready_o SHALL equal (count < DEPTH) from registered count; a dequeue in the same cycle SHALL NOT free a slot for a store at full.
REQ-018 Enqueue SHALL occur when store_i.valid && store_ready_o; store_i.valid while full SHALL be ignored; the committer holds it.
REQ-019 FSM SHALL have states IDLE, LOAD_REQ, STORE_REQ; reset state IDLE.
REQ-020 In IDLE, store wins if count>0 and any of: drain_i, count==DEPTH, starve_cnt==STARVE_LIMIT, or no grantable load.
  - otherwise a grantable load wins.
  - a load is grantable when load_valid_i && !load_conflict_o.
REQ-021 Store win SHALL load the head entry into the request registers with dc_we_o=1, then go to STORE_REQ; the entry stays in the FIFO.
REQ-022 Load win SHALL pulse load_grant_o for one cycle and register load_addr_i with dc_we_o=0, dc_wstrb_o=0, then go to LOAD_REQ.
REQ-023 dc_valid_o SHALL be 1 exactly in LOAD_REQ/STORE_REQ; request fields SHALL be held stable until dc_valid_o && dc_ready_i.
REQ-024 On handshake in STORE_REQ: rptr++, count--, wrapping at DEPTH, then go to IDLE.
  - On handshake in LOAD_REQ: go to IDLE.
  - There is one IDLE bubble between requests.
REQ-025 load_conflict_o SHALL be combinational: load_valid_i && some valid entry, including the in-flight head, has waddr[ADDR_WIDTH-1:2]==load_addr_i[ADDR_WIDTH-1:2].
REQ-026 starve_cnt SHALL:
  - increment, saturating at STARVE_LIMIT, on each load grant with count>0;
  - clear on each store grant;
  - clear on a load grant with count==0.
REQ-027 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-028 drain_i held high SHALL keep loads ungranted while count>0; empty_o SHALL be 1 iff count==0.

Reset
REQ-029 rst SHALL asynchronously force these values, including mid-transaction; any in-flight request is abandoned:
  - state=IDLE; wptr, rptr, count, starve_cnt = 0;
  - dc_valid_o=0, dc_we_o=0, dc_addr_o=0, dc_wstrb_o=0, dc_wdata_o=0;
  - load_grant_o=0, store_ready_o=1, empty_o=1.
REQ-030 Entry payload registers SHALL NOT need reset.

Verification
REQ-031 Single store:
  - stimulus: store {wstrb=4'hF, waddr=0x100, wdata=0xDEADBEEF}, no load, dc_ready_i=1;
  - response: dc_valid_o=1, we=1 two cycles after enqueue; empty_o=1 after the handshake.
REQ-032 Fill:
  - stimulus: 5 back-to-back stores, dc_ready_i=0;
  - response: store_ready_o=0 after the 4th store, the 5th store is not accepted, count_o=4.
REQ-033 Conflict:
  - stimulus: buffered store 0x200; load at 0x202;
  - response: load_conflict_o=1, no grant until the store handshakes; then load granted with dc_addr_o=0x202.
REQ-034 Starvation:
  - stimulus: 1 buffered store at 0x300; continuous non-conflicting loads, dc_ready_i=1;
  - response: exactly 8 load grants, then a store request, then starve_cnt=0.
REQ-035 Drain and ready-stall:
  - stimulus: drain_i=1 with 3 stores buffered and a load pending; dc_ready_i low for 3 cycles on the first store;
  - response: fields held stable while stalled; 3 stores issue in order before the load is granted.
REQ-036 Reset mid-transaction:
  - stimulus: rst asserted while in STORE_REQ with count=2;
  - response: next sample shows dc_valid_o=0, count_o=0, empty_o=1.
